sipo_frame_receiver: RTL
========================

# sipo_frame_receiver

- Serial-to-parallel receiver that reassembles framed words from a one-bit serial stream, such as the output of the parallel-in/serial-out shift stage.
- Each frame is hunted, shifted in LSB-first, checked for parity and stop-bit framing, then presented on a parallel bus with a valid/ready handshake.
- Sits directly downstream of the serializer and feeds the word-level consumer.

## Interface
Parameters:
- DATA_W, default 4: data bits per frame.
- PARITY_EN, default 1: 1 means the frame carries an even-parity bit after the data; 0 means no parity bit.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  reset, asynchronous, active-high.
- bit_en  input  1  serial bit strobe; serial_in is sampled only on edges where bit_en=1.
- serial_in  input  1  serial line; idle level 0.
- data_ready  input  1  consumer accepts the held word.
- data_out  output  DATA_W  received word.
- data_valid  output  1  data_out holds an unaccepted word.
- parity_err  output  1  parity check failed for the held word.
- frame_err  output  1  stop bit of the held word was not 0.
- overrun  output  1  sticky: a completed frame was dropped.
- busy  output  1  FSM is not IDLE.

## Operation
- Frame on serial_in, one bit per bit_en strobe:
  - start bit = 1;
  - DATA_W data bits, LSB first;
  - parity bit, only when PARITY_EN=1; value is even parity, so XOR of data and parity bit = 0;
  - stop bit = 0.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a strobe with serial_in=1, go to DATA and clear the bit counter. A strobe with serial_in=0 stays in IDLE.
  - DATA: each strobe shifts serial_in into the MSB of the shift register, shifting right, and increments the bit counter. On the DATA_W-th strobe, go to PARITY if PARITY_EN=1, else to STOP.
  - PARITY: one strobe captures the parity bit, then go to STOP.
  - STOP: one strobe samples the stop bit. That edge completes the frame; the FSM returns to IDLE.
  - Next start bit may arrive on the very next strobe.
- bit_en=0: FSM, counter and shift register hold.
- Bit counter width: clog2(DATA_W+1).
- Frame completion:
  - If data_valid=0, or data_valid=1 with data_ready=1 on the same edge:
    - load data_out from the shift register;
    - parity_err = XOR(data, parity bit), forced to 0 when PARITY_EN=0;
    - frame_err = (stop bit != 0);
    - set data_valid.
  - Otherwise (data_valid=1, data_ready=0): drop the new frame, set overrun, leave data_out and the error flags unchanged.
- Handshake: the word is accepted on any edge with data_valid=1 and data_ready=1. data_valid then drops, unless the same edge completes a new frame, in which case it stays 1 with the new word.
- Words with parity_err or frame_err set are still delivered. The flags are qualified by data_valid and remain stable while the word is held.
- overrun clears only on reset.

## Timing
- Reset values, applied immediately on asynchronous assertion:
  - FSM = IDLE; counter = 0; shift register = 0;
  - data_out = 0; data_valid = 0; parity_err = 0; frame_err = 0; overrun = 0; busy = 0.
- Reset asserted mid-frame discards the partial frame. After reset release, the first strobe with serial_in=1 is treated as a start bit.
- busy rises in the cycle after the start-bit edge and falls in the cycle after the stop-bit edge.
- Latency: data_valid, data_out and the error flags are registered and visible the cycle after the stop-bit sampling edge.
- Frame length is 2+DATA_W+PARITY_EN strobes. With bit_en held high, back-to-back frames produce one word per that many cycles.
- data_ready has no combinational path to any output.
- When a frame completes and an accept occurs on the same edge, both take effect: the old word is accepted and the new word is loaded. No overrun is flagged.

## Test plan
- Basic frame, DATA_W=4, PARITY_EN=1, bit_en=1 continuously:
  - Stimulus: serial_in 1,1,0,1,1,1,0 (start, data 4'hD LSB-first, parity 1, stop 0).
  - Response: busy for 6 cycles; data_out=4'hD, data_valid=1, parity_err=0, frame_err=0 on the cycle after the stop edge.
- Error flags:
  - Same frame with the parity bit flipped to 0 -> parity_err=1.
  - Same frame with the stop bit = 1 -> frame_err=1.
  - In both cases data_out=4'hD is still delivered.
- Overrun and same-edge accept:
  - Hold data_ready=0, send 4'h3 then 4'h9 -> data_out stays 4'h3 and overrun=1.
  - Repeat from reset with data_ready=1 on the completion edge of 4'h9 -> data_out=4'h9, data_valid stays 1, overrun=0.
- Strobe gating: bit_en toggling 1/0 every cycle with frame 4'hA -> same result as the basic case, delivered after 14 clock cycles. Idle strobes with serial_in=0 leave busy=0.
- Reset mid-frame: assert reset after 2 data bits -> all outputs return to reset values. A following complete frame for 4'h5 is received correctly.
- PARITY_EN=0 build: frame 1, data 4'h6 LSB-first, then stop 0 (6 strobes) -> data_out=4'h6; parity_err is always 0.

Source files
------------

// File: rtl/sipo_frame_receiver.sv
// Serial-to-parallel frame receiver: hunts a start bit, shifts data in LSB-first,
// checks even parity and stop framing, and holds the word behind a valid/ready handshake.
module sipo_frame_receiver #(
    parameter int DATA_W    = 4,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_en,
    input  logic              serial_in,
    input  logic              data_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   shift_reg;
    logic                parity_bit;
    logic [DATA_W:0]     shift_in;
    logic                frame_done;
    logic                load_word;

    // Even parity: data and parity bit together must XOR to zero.
    function automatic logic calc_parity_err(input logic [DATA_W-1:0] d, input logic p);
        if (PARITY_EN != 0) begin
            return ^{d, p};
        end else begin
            return 1'b0;
        end
    endfunction

    assign shift_in = {serial_in, shift_reg};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        load_word  = 1'b0;
        busy       = (state != IDLE);
        if (bit_en) begin
            case (state)
                IDLE:    if (serial_in) state_next = DATA;
                DATA:    if (bit_cnt == CNT_W'(DATA_W - 1))
                             state_next = (PARITY_EN != 0) ? PARITY : STOP;
                PARITY:  state_next = STOP;
                STOP:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
        frame_done = bit_en && (state == STOP);
        // A held word that is being accepted on this edge makes room for the new one.
        load_word  = frame_done && (!data_valid || data_ready);
    end

    // Shift/capture stage: only advances on bit strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else if (bit_en) begin
            case (state)
                IDLE: begin
                    if (serial_in) bit_cnt <= '0;
                end
                DATA: begin
                    shift_reg <= shift_in[DATA_W:1];
                    bit_cnt   <= bit_cnt + 1'b1;
                end
                PARITY: begin
                    parity_bit <= serial_in;
                end
                default: begin
                end
            endcase
        end
    end

    // Output holding stage: word, flags and handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (load_word) begin
            data_out   <= shift_reg;
            parity_err <= calc_parity_err(shift_reg, parity_bit);
            frame_err  <= serial_in;
            data_valid <= 1'b1;
        end else begin
            if (frame_done) overrun <= 1'b1;
            if (data_valid && data_ready) data_valid <= 1'b0;
        end
    end

endmodule
